// File: rtl/rr_arbiter_4_bh_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter.
package rr_arbiter_4_bh_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ID_W    = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Result of a round-robin search over a candidate vector
    typedef struct packed {
        logic            found;
        logic [ID_W-1:0] idx;
    } pick_t;

endpackage

// File: rtl/rr_arbiter_4_bh_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_arbiter_4_bh_if;
    import rr_arbiter_4_bh_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_id;
    logic               gnt_valid;
    logic               preempt;

    modport master (
        output req,
        input  gnt,
        input  gnt_id,
        input  gnt_valid,
        input  preempt
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_id,
        output gnt_valid,
        output preempt
    );

endinterface

// File: rtl/decoder_2_to_4_bh.sv
// 2-to-4 decoder with enable: y is one-hot at index a when e=1, else all zero.
module decoder_2_to_4_bh (
    input  logic [1:0] a,
    input  logic       e,
    output logic [3:0] y
);

    always_comb begin
        y = 4'b0000;
        if (e) begin
            case (a)
                2'd0:    y = 4'b0001;
                2'd1:    y = 4'b0010;
                2'd2:    y = 4'b0100;
                default: y = 4'b1000;
            endcase
        end
    end

endmodule

// File: rtl/rr_arbiter_4_bh.sv
// Round-robin arbiter for four requesters with optional hold timeout and
// back-to-back handover; the one-hot grant is produced by a 2-to-4 decoder.
module rr_arbiter_4_bh
    import rr_arbiter_4_bh_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input logic               clk,
    input logic               rst,
    rr_arbiter_4_bh_if.slave  bus
);

    localparam int unsigned     HC_W       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam bit              TIMEOUT_EN = (MAX_HOLD != 0);
    localparam logic [HC_W-1:0] HC_MAX     = TIMEOUT_EN ? HC_W'(MAX_HOLD - 1) : '0;

    state_t             state;
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    gnt_id;
    logic               gnt_valid;
    logic [HC_W-1:0]    hold_cnt;
    logic               preempt;

    logic [NUM_REQ-1:0] others;
    logic               owner_req;
    logic               timeout;
    pick_t              pick_any;
    pick_t              pick_oth;

    // Nearest set bit after p, wrapping, with p itself searched last
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] cand,
                                      input logic [ID_W-1:0]    p);
        pick_t           r;
        logic [ID_W-1:0] idx;
        r = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = p + ID_W'(k);
            if (cand[idx]) begin
                r.found = 1'b1;
                r.idx   = idx;
            end
        end
        return r;
    endfunction

    assign others    = bus.req & ~(NUM_REQ'(1) << gnt_id);
    assign owner_req = bus.req[gnt_id];
    assign pick_any  = rr_pick(bus.req, ptr);
    assign pick_oth  = rr_pick(others, ptr);
    assign timeout   = TIMEOUT_EN && (hold_cnt == HC_MAX) && (|others);

    // Arbitration state machine; a new grant always moves ptr to the winner
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            ptr       <= ID_W'(NUM_REQ - 1);
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            hold_cnt  <= '0;
            preempt   <= 1'b0;
        end else begin
            preempt <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_any.found) begin
                        state     <= ST_GRANT;
                        gnt_valid <= 1'b1;
                        gnt_id    <= pick_any.idx;
                        ptr       <= pick_any.idx;
                        hold_cnt  <= '0;
                    end
                end
                ST_GRANT: begin
                    if (!owner_req) begin
                        if (pick_oth.found) begin
                            gnt_id   <= pick_oth.idx;
                            ptr      <= pick_oth.idx;
                            hold_cnt <= '0;
                        end else begin
                            state     <= ST_IDLE;
                            gnt_valid <= 1'b0;
                            hold_cnt  <= '0;
                        end
                    end else if (timeout) begin
                        gnt_id   <= pick_oth.idx;
                        ptr      <= pick_oth.idx;
                        hold_cnt <= '0;
                        preempt  <= 1'b1;
                    end else if (hold_cnt != HC_MAX) begin
                        hold_cnt <= hold_cnt + HC_W'(1);
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    gnt_valid <= 1'b0;
                end
            endcase
        end
    end

    decoder_2_to_4_bh u_dec (
        .a (gnt_id),
        .e (gnt_valid),
        .y (bus.gnt)
    );

    assign bus.gnt_id    = gnt_id;
    assign bus.gnt_valid = gnt_valid;
    assign bus.preempt   = preempt;

endmodule

// File: tb/tb_rr_arbiter_4_bh.sv
// Bench for rr_arbiter_4_bh: three instances (MAX_HOLD 16/4/2) share one request
// vector; a queue-free reference model checks each every cycle, directed checks pin it.
module tb_rr_arbiter_4_bh;

    typedef struct {
        bit busy;
        int owner;
        int ptr;
        int age;
        bit pre;
    } mdl_t;

    localparam mdl_t MDL_RST = '{busy: 1'b0, owner: 0, ptr: 3, age: 0, pre: 1'b0};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;

    int checks = 0;
    int errors = 0;

    mdl_t m16 = MDL_RST;
    mdl_t m4  = MDL_RST;
    mdl_t m2  = MDL_RST;

    rr_arbiter_4_bh_if if16 ();
    rr_arbiter_4_bh_if if4 ();
    rr_arbiter_4_bh_if if2 ();

    assign if16.req = req;
    assign if4.req  = req;
    assign if2.req  = req;

    rr_arbiter_4_bh #(.MAX_HOLD(16)) u16 (.clk(clk), .rst(rst), .bus(if16));
    rr_arbiter_4_bh #(.MAX_HOLD(4))  u4  (.clk(clk), .rst(rst), .bus(if4));
    rr_arbiter_4_bh #(.MAX_HOLD(2))  u2  (.clk(clk), .rst(rst), .bus(if2));

    always #5 clk = ~clk;

    // First requester found walking forward from ptr+1, wrapping; -1 if none
    function automatic int search(input logic [3:0] r, input int p);
        for (int k = 1; k <= 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    // One clock edge of the arbiter as described in plain terms
    function automatic mdl_t advance(input mdl_t m, input logic [3:0] r, input int maxh);
        mdl_t       n;
        logic [3:0] oth;
        int         w;
        n     = m;
        n.pre = 1'b0;
        if (!m.busy) begin
            w = search(r, m.ptr);
            if (w >= 0) begin
                n.busy = 1'b1; n.owner = w; n.ptr = w; n.age = 0;
            end
        end else begin
            oth = r;
            oth[m.owner] = 1'b0;
            if (!r[m.owner]) begin
                w = search(oth, m.ptr);
                if (w >= 0) begin
                    n.owner = w; n.ptr = w; n.age = 0;
                end else begin
                    n.busy = 1'b0; n.age = 0;
                end
            end else if (maxh != 0 && m.age >= maxh - 1 && oth != 4'b0000) begin
                w = search(oth, m.ptr);
                n.owner = w; n.ptr = w; n.age = 0; n.pre = 1'b1;
            end else begin
                n.age = m.age + 1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m16 <= MDL_RST;
            m4  <= MDL_RST;
            m2  <= MDL_RST;
        end else begin
            m16 <= advance(m16, req, 16);
            m4  <= advance(m4, req, 4);
            m2  <= advance(m2, req, 2);
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(input string tag, input mdl_t m, input logic [3:0] g,
                            input logic [1:0] id, input logic v, input logic p);
        cmp({tag, ".gnt"}, 32'(g), m.busy ? (32'd1 << m.owner) : 32'd0);
        cmp({tag, ".gnt_valid"}, 32'(v), 32'(m.busy));
        if (m.busy) cmp({tag, ".gnt_id"}, 32'(id), 32'(m.owner));
        cmp({tag, ".preempt"}, 32'(p), 32'(m.pre));
    endtask

    // Continuous model comparison, away from the active edge
    always @(negedge clk) begin
        cmp_inst("mh16", m16, if16.gnt, if16.gnt_id, if16.gnt_valid, if16.preempt);
        cmp_inst("mh4",  m4,  if4.gnt,  if4.gnt_id,  if4.gnt_valid,  if4.preempt);
        cmp_inst("mh2",  m2,  if2.gnt,  if2.gnt_id,  if2.gnt_valid,  if2.preempt);
    end

    task automatic step(input logic [3:0] r);
        req = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp_g;
        logic       exp_p;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        cmp("rst_gnt", 32'(if16.gnt), 32'h0);
        cmp("rst_valid", 32'(if16.gnt_valid), 32'h0);
        cmp("rst_id", 32'(if16.gnt_id), 32'h0);
        cmp("rst_preempt", 32'(if16.preempt), 32'h0);
        rst = 1'b0;

        // Reset mid-grant drops the grant immediately, then ptr restarts at 3
        step(4'b1111);
        cmp("t1_first_gnt", 32'(if16.gnt), 32'h1);
        step(4'b1111);
        rst = 1'b1;
        #1;
        cmp("t1_midrst_gnt", 32'(if16.gnt), 32'h0);
        cmp("t1_midrst_valid", 32'(if16.gnt_valid), 32'h0);
        cmp("t1_midrst_preempt", 32'(if16.preempt), 32'h0);
        step(4'b0000);
        rst = 1'b0;
        step(4'b1111);
        cmp("t1_after_rst_gnt", 32'(if16.gnt), 32'h1);

        // Rotation: each owner drops its request one cycle after its grant
        step(4'b1110);
        cmp("t2_gnt1", 32'(if16.gnt), 32'h2);
        step(4'b1101);
        cmp("t2_gnt2", 32'(if16.gnt), 32'h4);
        step(4'b1011);
        cmp("t2_gnt3", 32'(if16.gnt), 32'h8);
        step(4'b0111);
        cmp("t2_gnt0", 32'(if16.gnt), 32'h1);
        cmp("t2_valid", 32'(if16.gnt_valid), 32'h1);
        step(4'b0000);
        cmp("t2_idle", 32'(if16.gnt_valid), 32'h0);

        // Idle and return: ptr follows the last grant, not idle cycles
        step(4'b0000);
        step(4'b1000);
        cmp("t6_gnt3", 32'(if16.gnt), 32'h8);
        cmp("t6_id3", 32'(if16.gnt_id), 32'h3);
        step(4'b0000);
        cmp("t6_drop", 32'(if16.gnt_valid), 32'h0);
        step(4'b1001);
        cmp("t6_wrap_gnt0", 32'(if16.gnt), 32'h1);
        step(4'b0000);

        // Fresh reset so req[0] leads the timeout test
        rst = 1'b1;
        step(4'b0000);
        rst = 1'b0;

        // Timeout with MAX_HOLD=4 alternating between two requesters
        for (int k = 1; k <= 9; k++) begin
            step(4'b0011);
            exp_g = (k <= 4 || k == 9) ? 4'b0001 : 4'b0010;
            exp_p = (k == 5 || k == 9);
            cmp($sformatf("t3_gnt_k%0d", k), 32'(if4.gnt), 32'(exp_g));
            cmp($sformatf("t3_pre_k%0d", k), 32'(if4.preempt), 32'(exp_p));
        end
        step(4'b0000);

        // No contention: single requester never preempted
        for (int k = 1; k <= 20; k++) begin
            step(4'b0100);
            cmp($sformatf("t4_gnt_k%0d", k), 32'(if4.gnt), 32'h4);
            cmp($sformatf("t4_pre_k%0d", k), 32'(if4.preempt), 32'h0);
        end
        step(4'b0000);

        // Release on the timeout edge counts as a release, not a preempt
        step(4'b0011);
        cmp("t5_gnt0", 32'(if2.gnt), 32'h1);
        step(4'b0011);
        cmp("t5_hold", 32'(if2.gnt), 32'h1);
        cmp("t5_hold_pre", 32'(if2.preempt), 32'h0);
        step(4'b0010);
        cmp("t5_gnt1", 32'(if2.gnt), 32'h2);
        cmp("t5_no_pre", 32'(if2.preempt), 32'h0);
        step(4'b0000);
        step(4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
